// File: rtl/sram_sample_pkg.sv
// Shared types and default timing for the SRAM power-cycle sampler.
// Holds the FSM state enum, default cycle counts and small helpers.
package sram_sample_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PWR_OFF = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_EMIT    = 3'd5,
    ST_NEXT    = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

  localparam int DEF_OFF_CYCLES    = 5_000_000;
  localparam int DEF_SETTLE_CYCLES = 50_000;
  localparam int DEF_NUM_RUNS      = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic pwr_on(input state_e s);
    return s inside {ST_SETTLE, ST_RD_REQ, ST_RD_WAIT,
                     ST_EMIT, ST_NEXT};
  endfunction

endpackage

// File: rtl/sample_timer.sv
// Loadable down-counter timing the power-off and settle phases.
// Ports: clk, rst_n, i_load/i_val (load), o_zero (count is zero).
module sample_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_sample_sched.sv
// Power-cycles an SRAM, reads every word and streams it out, per run.
// Ports: clock/reset, start/stop, pwr enable, read port, sample stream, status.
module sram_sample_sched
  import sram_sample_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int OFF_CYCLES    = DEF_OFF_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int NUM_RUNS      = DEF_NUM_RUNS
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RST_N,
  input  logic              start,
  input  logic              stop,
  output logic              sram_pwr_en,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [7:0]        run_idx,
  output logic              LEDR0
);

  localparam int TW =
    $clog2(max2(OFF_CYCLES, SETTLE_CYCLES)) + 1;
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] SET_LD = TW'(SETTLE_CYCLES - 1);

  state_e        r_state;
  state_e        w_next;
  logic          r_stop_pend;
  logic          w_stop;
  logic          w_xfer;
  logic          w_last_addr;
  logic          w_last_run;
  logic          w_tmr_load;
  logic [TW-1:0] w_tmr_val;
  logic          w_tmr_zero;

  // stop seen in RD_WAIT/EMIT is held until the
  // pending read or handshake completes
  assign w_stop      = stop | r_stop_pend;
  assign w_xfer      = (r_state == ST_EMIT) & out_valid
                       & out_ready;
  assign w_last_addr = (rd_addr == '1);
  assign w_last_run  = (NUM_RUNS != 0) &&
                       ((int'(run_idx) + 1) == NUM_RUNS);

  sample_timer #(
    .W(TW)
  ) u_timer (
    .clk   (MAX10_CLK1_50),
    .rst_n (RST_N),
    .i_load(w_tmr_load),
    .i_val (w_tmr_val),
    .o_zero(w_tmr_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_tmr_load = 1'b0;
    w_tmr_val  = OFF_LD;
    unique case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_next     = ST_PWR_OFF;
          w_tmr_load = 1'b1;
        end
      end
      ST_PWR_OFF: begin
        if (stop) begin
          w_next = ST_DONE;
        end else if (w_tmr_zero) begin
          w_next     = ST_SETTLE;
          w_tmr_load = 1'b1;
          w_tmr_val  = SET_LD;
        end
      end
      ST_SETTLE: begin
        if (stop)            w_next = ST_DONE;
        else if (w_tmr_zero) w_next = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        if (stop)        w_next = ST_DONE;
        else if (rd_ack) w_next = ST_EMIT;
        else             w_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_ack) begin
          w_next = w_stop ? ST_DONE : ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_xfer) begin
          if (w_stop)           w_next = ST_DONE;
          else if (w_last_addr) w_next = ST_NEXT;
          else                  w_next = ST_RD_REQ;
        end
      end
      ST_NEXT: begin
        if (stop || w_last_run) begin
          w_next = ST_DONE;
        end else begin
          w_next     = ST_PWR_OFF;
          w_tmr_load = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // outputs are registered from the next state so
  // the GPIO and handshake lines never glitch
  always_ff @(posedge MAX10_CLK1_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_stop_pend <= 1'b0;
      sram_pwr_en <= 1'b0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      run_idx     <= '0;
      LEDR0       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_stop_pend <= (r_state != ST_IDLE) && w_stop;
      sram_pwr_en <= pwr_on(w_next);
      rd_req      <= (w_next == ST_RD_REQ) ||
                     (w_next == ST_RD_WAIT);
      busy        <= (w_next != ST_IDLE) &&
                     (w_next != ST_DONE);
      out_valid   <= (w_next == ST_EMIT);
      out_last    <= (w_next == ST_EMIT) && w_last_addr;
      if (w_next == ST_EMIT && r_state != ST_EMIT) begin
        out_data <= rd_data;
      end
      if (r_state == ST_SETTLE && w_next == ST_RD_REQ) begin
        rd_addr <= '0;
      end else if (w_xfer && w_next == ST_RD_REQ) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
      if (r_state == ST_IDLE && w_next == ST_PWR_OFF) begin
        run_idx <= '0;
      end else if (r_state == ST_NEXT) begin
        run_idx <= run_idx + 8'd1;
      end
      if (r_state == ST_NEXT) begin
        LEDR0 <= ~LEDR0;
      end
    end
  end

endmodule

// File: tb/tb_sram_sample_sched.sv
// Self-checking bench for sram_sample_sched.
// Table-driven sessions plus stop, reset and free-running corner cases.
module tb_sram_sample_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- DUT A: NUM_RUNS=2 ----------------
  logic        a_rst_n = 1'b0;
  logic        a_start = 1'b0;
  logic        a_stop = 1'b0;
  logic        a_pwr;
  logic        a_rd_req;
  logic [1:0]  a_rd_addr;
  logic        a_rd_ack = 1'b0;
  logic [15:0] a_rd_data = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b1;
  logic [15:0] a_out_data;
  logic        a_out_last;
  logic        a_busy;
  logic [7:0]  a_run_idx;
  logic        a_led;

  sram_sample_sched #(
    .ADDR_W(2), .DATA_W(16), .OFF_CYCLES(4),
    .SETTLE_CYCLES(3), .NUM_RUNS(2)
  ) u_dut (
    .MAX10_CLK1_50(clk), .RST_N(a_rst_n),
    .start(a_start), .stop(a_stop),
    .sram_pwr_en(a_pwr), .rd_req(a_rd_req),
    .rd_addr(a_rd_addr), .rd_ack(a_rd_ack),
    .rd_data(a_rd_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy),
    .run_idx(a_run_idx), .LEDR0(a_led)
  );

  // ---------------- DUT B: NUM_RUNS=0 ----------------
  logic        b_rst_n = 1'b0;
  logic        b_start = 1'b0;
  logic        b_stop = 1'b0;
  logic        b_pwr;
  logic        b_rd_req;
  logic [1:0]  b_rd_addr;
  logic        b_rd_ack = 1'b0;
  logic [15:0] b_rd_data = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [15:0] b_out_data;
  logic        b_out_last;
  logic        b_busy;
  logic [7:0]  b_run_idx;
  logic        b_led;

  sram_sample_sched #(
    .ADDR_W(2), .DATA_W(16), .OFF_CYCLES(4),
    .SETTLE_CYCLES(3), .NUM_RUNS(0)
  ) u_dut0 (
    .MAX10_CLK1_50(clk), .RST_N(b_rst_n),
    .start(b_start), .stop(b_stop),
    .sram_pwr_en(b_pwr), .rd_req(b_rd_req),
    .rd_addr(b_rd_addr), .rd_ack(b_rd_ack),
    .rd_data(b_rd_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy),
    .run_idx(b_run_idx), .LEDR0(b_led)
  );

  // ---------------- scoreboard / memory model A ----------------
  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mem[4];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          acks = 0;
  logic        discard = 1'b0;
  logic [1:0]  exp_addr = 2'd0;

  always @(negedge clk) begin : resp_a
    exp_t e;
    if (a_rd_req) begin
      if (wait_cnt >= ack_delay) begin
        a_rd_ack  = 1'b1;
        a_rd_data = mem[exp_addr];
        check("rd_addr_order", 32'(a_rd_addr), 32'(exp_addr));
        e.data = mem[exp_addr];
        e.last = (exp_addr == 2'd3);
        if (!discard) q.push_back(e);
        acks++;
        exp_addr = exp_addr + 2'd1;
        wait_cnt = 0;
      end else begin
        a_rd_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      a_rd_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  int          a_words = 0;
  int          a_toggles = 0;
  logic        a_prev_led = 1'b0;
  logic        hold_ready = 1'b0;
  logic        stall_arm = 1'b0;
  int          stall_left = 0;
  logic [15:0] stall_data = '0;
  logic [1:0]  stall_addr = '0;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (hold_ready) begin
      a_out_ready = 1'b0;
    end else if (stall_left > 0) begin
      check("stall_valid", 32'(a_out_valid), 32'd1);
      check("stall_data", 32'(a_out_data), 32'(stall_data));
      check("stall_addr", 32'(a_rd_addr), 32'(stall_addr));
      stall_left--;
      if (stall_left == 0) a_out_ready = 1'b1;
    end else if (stall_arm && a_out_valid &&
                 a_rd_addr == 2'd1) begin
      stall_arm   = 1'b0;
      a_out_ready = 1'b0;
      stall_left  = 5;
      stall_data  = a_out_data;
      stall_addr  = a_rd_addr;
    end else begin
      a_out_ready = 1'b1;
    end
    if (a_out_valid && a_out_ready) begin
      a_words++;
      check("sb_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("word_data", 32'(a_out_data), 32'(e.data));
        check("word_last", 32'(a_out_last), 32'(e.last));
      end
    end
    if (a_led !== a_prev_led) a_toggles++;
    a_prev_led = a_led;
  end

  // ---------------- monitor / memory model B ----------------
  int         b_words = 0;
  int         b_toggles = 0;
  logic       b_prev_led = 1'b0;
  logic [7:0] b_prev_idx = '0;
  logic       b_wrapped = 1'b0;
  logic [1:0] b_exp = '0;

  always @(negedge clk) begin : mon_b
    b_rd_ack  = b_rd_req;
    b_rd_data = 16'h0100 + 16'(b_rd_addr);
    if (b_out_valid && b_out_ready) begin
      b_words++;
      check("b_data", 32'(b_out_data), 32'(16'h0100 + 16'(b_exp)));
      check("b_last", 32'(b_out_last), 32'(b_exp == 2'd3));
      b_exp = b_exp + 2'd1;
    end
    if (b_led !== b_prev_led) b_toggles++;
    b_prev_led = b_led;
    if (b_prev_idx == 8'd255 && b_run_idx == 8'd0) b_wrapped = 1'b1;
    b_prev_idx = b_run_idx;
  end

  // ---------------- test table ----------------
  typedef struct {
    int          ack_delay;
    logic        stall;
    logic        extra;
    logic [15:0] base;
    int          exp_words;
    int          exp_toggles;
    logic [7:0]  exp_idx;
  } vec_t;

  vec_t tbl[3];

  task automatic check_rst(input string tag);
    check({tag, "_pwr"}, 32'(a_pwr), 32'd0);
    check({tag, "_rd_req"}, 32'(a_rd_req), 32'd0);
    check({tag, "_rd_addr"}, 32'(a_rd_addr), 32'd0);
    check({tag, "_valid"}, 32'(a_out_valid), 32'd0);
    check({tag, "_data"}, 32'(a_out_data), 32'd0);
    check({tag, "_last"}, 32'(a_out_last), 32'd0);
    check({tag, "_busy"}, 32'(a_busy), 32'd0);
    check({tag, "_run_idx"}, 32'(a_run_idx), 32'd0);
    check({tag, "_led"}, 32'(a_led), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic do_session(input logic extra, input int exp_words,
                            input int exp_tog, input logic [7:0] exp_idx);
    int c;
    int w0;
    int t0;
    w0 = a_words;
    t0 = a_toggles;
    exp_addr = 2'd0;
    pulse_start();
    check("busy_rise", 32'(a_busy), 32'd1);
    c = 0;
    while (!a_pwr && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("pwr_off_len", 32'(c), 32'd4);
    c = 0;
    while (!a_rd_req && c < 100) begin
      check("pwr_on_settle", 32'(a_pwr), 32'd1);
      @(negedge clk);
      c++;
    end
    check("settle_len", 32'(c), 32'd3);
    check("first_run_idx", 32'(a_run_idx), 32'd0);
    check("first_rd_addr", 32'(a_rd_addr), 32'd0);
    if (extra) begin
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
    end
    c = 0;
    while (a_busy && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("busy_fall", 32'(a_busy), 32'd0);
    repeat (2) @(negedge clk);
    check("words", 32'(a_words - w0), 32'(exp_words));
    check("led_toggles", 32'(a_toggles - t0), 32'(exp_tog));
    check("run_idx_end", 32'(a_run_idx), 32'(exp_idx));
    check("pwr_done", 32'(a_pwr), 32'd0);
    check("sb_empty", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("stay_idle", 32'(a_busy), 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: run did not complete, %0d checks, %0d errors",
             n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int c;
    int w0;
    int a0;
    logic seen;

    tbl[0] = '{ack_delay: 0, stall: 1'b0, extra: 1'b0,
               base: 16'h1000, exp_words: 8, exp_toggles: 2,
               exp_idx: 8'd2};
    tbl[1] = '{ack_delay: 0, stall: 1'b1, extra: 1'b1,
               base: 16'h2A50, exp_words: 8, exp_toggles: 2,
               exp_idx: 8'd2};
    tbl[2] = '{ack_delay: 2, stall: 1'b0, extra: 1'b0,
               base: 16'h7F00, exp_words: 8, exp_toggles: 2,
               exp_idx: 8'd2};

    repeat (3) @(negedge clk);
    check_rst("rst");
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // start and stop together must stay idle
    a_start = 1'b1;
    a_stop  = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_stop  = 1'b0;
    repeat (2) @(negedge clk);
    check("start_stop_busy", 32'(a_busy), 32'd0);
    check("start_stop_pwr", 32'(a_pwr), 32'd0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] = tbl[r].base + 16'(i * 16'h0111);
      end
      ack_delay = tbl[r].ack_delay;
      stall_arm = tbl[r].stall;
      do_session(tbl[r].extra, tbl[r].exp_words,
                 tbl[r].exp_toggles, tbl[r].exp_idx);
      if (tbl[r].stall) check("stall_used", 32'(stall_arm), 32'd0);
    end
    ack_delay = 0;

    // stop during SETTLE
    w0 = a_words;
    pulse_start();
    c = 0;
    while (!a_pwr && c < 100) begin
      @(negedge clk);
      c++;
    end
    a_stop = 1'b1;
    @(negedge clk);
    a_stop = 1'b0;
    check("stop_settle_busy", 32'(a_busy), 32'd0);
    check("stop_settle_pwr", 32'(a_pwr), 32'd0);
    check("stop_settle_rd_req", 32'(a_rd_req), 32'd0);
    repeat (5) @(negedge clk);
    check("stop_settle_words", 32'(a_words - w0), 32'd0);
    check("stop_settle_idle", 32'(a_busy), 32'd0);

    // stop in RD_WAIT with a delayed ack
    ack_delay = 3;
    discard   = 1'b1;
    exp_addr  = 2'd0;
    a0 = acks;
    w0 = a_words;
    pulse_start();
    c = 0;
    while (!a_rd_req && c < 100) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    a_stop = 1'b1;
    @(negedge clk);
    a_stop = 1'b0;
    check("rdwait_hold_req", 32'(a_rd_req), 32'd1);
    check("rdwait_hold_busy", 32'(a_busy), 32'd1);
    c = 0;
    seen = 1'b0;
    while (a_busy && c < 50) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
      c++;
    end
    repeat (3) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
    end
    check("rdwait_no_valid", 32'(seen), 32'd0);
    check("rdwait_acked", 32'(acks - a0), 32'd1);
    check("rdwait_done", 32'(a_busy), 32'd0);
    check("rdwait_words", 32'(a_words - w0), 32'd0);
    discard   = 1'b0;
    ack_delay = 0;

    // reset while a word sits in EMIT during run 2
    for (int i = 0; i < 4; i++) mem[i] = 16'h5500 + 16'(i);
    exp_addr = 2'd0;
    pulse_start();
    c = 0;
    while (a_run_idx != 8'd1 && c < 500) begin
      @(negedge clk);
      c++;
    end
    hold_ready = 1'b1;
    c = 0;
    while (!a_out_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("emit_before_rst", 32'(a_out_valid), 32'd1);
    check("led_before_rst", 32'(a_led), 32'd1);
    a_rst_n = 1'b0;
    #1;
    check_rst("mid_rst");
    @(negedge clk);
    a_rst_n    = 1'b1;
    hold_ready = 1'b0;
    q.delete();
    repeat (3) @(negedge clk);
    check("post_rst_valid", 32'(a_out_valid), 32'd0);
    check("post_rst_busy", 32'(a_busy), 32'd0);
    do_session(1'b0, 8, 2, 8'd2);

    // free-running session: 300 runs, run_idx wraps
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    c = 0;
    while (b_toggles < 300 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check("b_runs", 32'(b_toggles), 32'd300);
    check("b_wrapped", 32'(b_wrapped), 32'd1);
    check("b_run_idx", 32'(b_run_idx), 32'd44);
    check("b_busy", 32'(b_busy), 32'd1);
    check("b_words", 32'(b_words), 32'd1200);
    b_stop = 1'b1;
    @(negedge clk);
    b_stop = 1'b0;
    c = 0;
    while (b_busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("b_stop_done", 32'(b_busy), 32'd0);
    check("b_stop_pwr", 32'(b_pwr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
